pipeline_run_ctrl: RTL
======================

# pipeline_run_ctrl

Synthesizable run controller for the 5-stage RISC-V `pipeline` core. It replaces fixed-delay reset and fixed-runtime termination with a parametrised sequencer. The block holds the core in reset for a programmable number of cycles, then counts cycles and retired instructions. It detects program end on ECALL/EBREAK or a jump-to-self loop, and reports pass, fail or timeout. It sits between the top-level clock/reset and the core, and drives the core's reset input.

## Interface
Parameters:
- `RST_CYCLES`, 4: cycles `core_rst` stays high after `rst` deasserts (≥1).
- `MAX_CYCLES`, 250: run-phase cycle budget before timeout (≥1).
- `DRAIN_CYCLES`, 4: cycles waited after halt detection before `done` (≥0).
- `SELF_LOOP_LIMIT`, 3: consecutive retirements at the same PC that count as a halt (≥2).
- `CNT_W`, 32: width of the cycle and instret counters.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `core_rst` output 1: reset to the core; active-high.
- `retire_valid` input 1: an instruction retired this cycle (WB stage).
- `retire_pc` input 32: PC of the retiring instruction.
- `retire_instr` input 32: encoding of the retiring instruction.
- `a0_value` input 32: current x10 value, sampled at halt.
- `running` output 1: high in RUN.
- `done` output 1: high in DONE; sticky until `rst`.
- `pass` output 1: valid when `done`.
- `timeout` output 1: valid when `done`.
- `cycle_count` output CNT_W: run-phase cycles elapsed.
- `instret_count` output CNT_W: retirements counted in RUN.
- `halt_pc` output 32: PC of the halting instruction, or of the loop.

## Operation
- FSM states: HOLD, RUN, DRAIN, DONE.
- HOLD:
  - `core_rst`=1; a hold counter counts 0..RST_CYCLES-1.
  - When count = RST_CYCLES-1, the next state is RUN.
- RUN:
  - `core_rst`=0, `running`=1.
  - `cycle_count` increments every cycle; `instret_count` increments on `retire_valid`.
- Halt conditions, evaluated only in RUN on `retire_valid`:
  - `retire_instr`==0x00000073 (ECALL) or 0x00100073 (EBREAK): halt; capture `a0_value` and `retire_pc`.
  - Self-loop: a loop counter tracks consecutive retirements with an identical `retire_pc`. Any different PC resets it to 1. When it reaches SELF_LOOP_LIMIT, halt; capture that PC; the captured a0 is forced nonzero, so the result is a fail.
- Halt detection moves the FSM to DRAIN.
- Timeout:
  - In RUN, `cycle_count` = MAX_CYCLES-1 with no halt that cycle leads to DONE with `timeout`=1, `pass`=0.
  - If a halt and the timeout cycle coincide, the halt wins and the FSM goes to DRAIN.
- DRAIN:
  - Counters freeze; `running`=0; the core keeps running, `core_rst`=0.
  - The drain counter goes to DONE after DRAIN_CYCLES cycles. DRAIN_CYCLES=0 means DONE on the next cycle.
- DONE:
  - `done`=1; `pass`=1 iff halt was ECALL/EBREAK and captured a0==0.
  - `core_rst`=1 to freeze the core; all outputs hold.
- Counters saturate at all-ones and do not wrap.
- `retire_valid` outside RUN is ignored.

## Timing
- `rst` is sampled on a rising edge. It forces HOLD, clears every counter, and clears `done`, `pass`, `timeout` and `halt_pc`. This applies from any state, including mid-RUN or mid-DRAIN.
- Reset values: `core_rst`=1, `running`=0, `done`=0, `pass`=0, `timeout`=0, `cycle_count`=0, `instret_count`=0, `halt_pc`=0.
- All outputs are registered; no combinational path from any input to any output.
- `core_rst` is high for exactly RST_CYCLES cycles after the first edge with `rst`=0. `running` rises in the same cycle `core_rst` falls.
- Halt latency:
  - The retire at edge N is seen at edge N.
  - The state is DRAIN after edge N, and `running`=0 in the cycle after N.
  - The retiring halt instruction is included in `instret_count`.
- `done` rises DRAIN_CYCLES+1 cycles after the halt edge.
- Timeout: `done` and `timeout` rise together on the edge ending cycle MAX_CYCLES of RUN.

## Test plan
- Reset sequencing: defaults, `rst` high for 2 cycles then low → `core_rst` high for exactly 4 more cycles, then `running`=1 with `cycle_count`=0.
- ECALL pass: 10 retires of distinct PCs, then ECALL at PC 0x28 with `a0_value`=0 → `instret_count`=11, `halt_pc`=0x28. `done` arrives 5 cycles later with `pass`=1, `timeout`=0.
- EBREAK fail: EBREAK with `a0_value`=7 → `done`=1, `pass`=0, `timeout`=0.
- Self-loop: three consecutive retires at PC 0x40 → halt with `halt_pc`=0x40, `pass`=0. A pattern of 0x40, 0x44, 0x40 must not halt.
- Timeout:
  - MAX_CYCLES=20, no halt → `done`=1, `timeout`=1, `cycle_count`=19 frozen.
  - ECALL on the final cycle → DRAIN path, `timeout`=0.
- Reset mid-run: assert `rst` during DRAIN → next cycle all outputs at reset values and `core_rst`=1. The sequence then restarts cleanly.

Source files
------------

// File: rtl/pipeline_run_ctrl_if.sv
// Run-controller bus: retirement stream from the core in, sequencing and
// status out. The master side is the run controller, the slave side is the
// core/top-level that feeds retirements and consumes status.
interface pipeline_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             core_rst;
  logic             retire_valid;
  logic [31:0]      retire_pc;
  logic [31:0]      retire_instr;
  logic [31:0]      a0_value;
  logic             running;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;
  logic [31:0]      halt_pc;

  modport master (
    input  retire_valid, retire_pc, retire_instr, a0_value,
    output core_rst, running, done, pass, timeout,
           cycle_count, instret_count, halt_pc
  );

  modport slave (
    output retire_valid, retire_pc, retire_instr, a0_value,
    input  core_rst, running, done, pass, timeout,
           cycle_count, instret_count, halt_pc
  );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run controller for the 5-stage core: holds the core in reset, runs it
// while counting cycles/retirements, detects program end (ECALL/EBREAK or
// a jump-to-self loop) or timeout, drains, then freezes and reports.
module pipeline_run_ctrl #(
  parameter int RST_CYCLES      = 4,
  parameter int MAX_CYCLES      = 250,
  parameter int DRAIN_CYCLES    = 4,
  parameter int SELF_LOOP_LIMIT = 3,
  parameter int CNT_W           = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_run_ctrl_if.master bus
);
  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int LW = $clog2(SELF_LOOP_LIMIT + 1);

  localparam logic [31:0]      INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0]      INSTR_EBREAK = 32'h0010_0073;
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;
  localparam logic [CNT_W-1:0] CYC_LAST     = CNT_W'(MAX_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_LAST    = HW'(RST_CYCLES - 1);
  localparam logic [DW-1:0]    DRAIN_LAST   = DW'(DRAIN_CYCLES);
  localparam logic [LW-1:0]    LOOP_LIMIT   = LW'(SELF_LOOP_LIMIT);

  typedef enum logic [1:0] {HOLD, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [DW-1:0]    drain_cnt;
  logic [LW-1:0]    loop_cnt;
  logic [31:0]      last_pc;
  logic             halt_ok;     // halt was ECALL/EBREAK with a0 == 0

  logic             core_rst_q, running_q, done_q, pass_q, timeout_q;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic [31:0]      halt_pc_q;

  logic             is_sys, same_pc, loop_halt, halt, tmo;
  logic [LW-1:0]    loop_nxt;

  // Halt / timeout detection for the current RUN cycle
  always_comb begin
    is_sys    = (bus.retire_instr == INSTR_ECALL) || (bus.retire_instr == INSTR_EBREAK);
    // loop_cnt == 0 means no retirement seen yet in this run
    same_pc   = (loop_cnt != '0) && (bus.retire_pc == last_pc);
    loop_nxt  = LW'(1);
    if (same_pc)
      loop_nxt = (loop_cnt == LOOP_LIMIT) ? loop_cnt : loop_cnt + 1'b1;
    loop_halt = (loop_nxt == LOOP_LIMIT);
    halt      = (state == RUN) && bus.retire_valid && (is_sys || loop_halt);
    // a halt on the last budgeted cycle takes priority over the timeout
    tmo       = (state == RUN) && !halt && (cycle_q == CYC_LAST);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      drain_cnt  <= '0;
      loop_cnt   <= '0;
      last_pc    <= '0;
      halt_ok    <= 1'b0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cycle_q    <= '0;
      instret_q  <= '0;
      halt_pc_q  <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_rst_q <= 1'b0;
            running_q  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          // the halting instruction itself is counted as retired
          if (bus.retire_valid) begin
            loop_cnt <= loop_nxt;
            last_pc  <= bus.retire_pc;
            if (instret_q != CNT_SAT) instret_q <= instret_q + 1'b1;
          end
          if (halt) begin
            state     <= DRAIN;
            running_q <= 1'b0;
            halt_pc_q <= bus.retire_pc;
            // a self-loop halt is always a fail, whatever a0 holds
            halt_ok   <= is_sys && (bus.a0_value == 32'd0);
          end else if (tmo) begin
            state      <= DONE;
            running_q  <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
          end else if (cycle_q != CNT_SAT) begin
            // cycle_count freezes at the value of the last RUN cycle
            cycle_q <= cycle_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state      <= DONE;
            core_rst_q <= 1'b1;
            done_q     <= 1'b1;
            pass_q     <= halt_ok;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: ;
        default: state <= HOLD;
      endcase
    end
  end

  assign bus.core_rst      = core_rst_q;
  assign bus.running       = running_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.timeout       = timeout_q;
  assign bus.cycle_count   = cycle_q;
  assign bus.instret_count = instret_q;
  assign bus.halt_pc       = halt_pc_q;
endmodule
